// File: rtl/pulse_train_tx_if.sv
// Handshake bundle for pulse_train_tx: the sequencer drives clock-enable, start and
// count, and the transmitter returns the line level and status.
interface pulse_train_tx_if #(
  parameter int COUNT_W = 4
);
  logic               CE;
  logic               start;
  logic [COUNT_W-1:0] num_pulses;
  logic               data_out;
  logic               busy;
  logic               done;

  modport master (
    output CE,
    output start,
    output num_pulses,
    input  data_out,
    input  busy,
    input  done
  );

  modport slave (
    input  CE,
    input  start,
    input  num_pulses,
    output data_out,
    output busy,
    output done
  );
endinterface

// File: rtl/pulse_train_tx.sv
// Emits N square pulses whose high and low phases each last HOLD_TICKS CE ticks,
// so a far-end inertial filter with a shorter consecutive-sample window passes every edge.
module pulse_train_tx #(
  parameter int HOLD_TICKS = 12,
  parameter int COUNT_W    = 4
) (
  input  logic            clk,
  input  logic            synch_reset,
  pulse_train_tx_if.slave bus
);

  localparam int                TICK_W    = $clog2(HOLD_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HOLD_TICKS - 1);

  // IDLE: line low, waiting for start | HIGH: high phase | LOW: low phase, incl. trailing one
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HIGH = 2'b01;
  localparam logic [1:0] ST_LOW  = 2'b10;

  logic [1:0]         state_q,     state_d;
  logic [TICK_W-1:0]  tick_q,      tick_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic               data_q,      data_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = done_q;

    if (bus.CE) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.num_pulses != '0) begin
              remaining_d = bus.num_pulses;
              tick_d      = '0;
              data_d      = 1'b1;
              busy_d      = 1'b1;
              state_d     = ST_HIGH;
            end else begin
              done_d = 1'b1;
            end
          end
        end

        ST_HIGH: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            data_d  = 1'b0;
            state_d = ST_LOW;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        ST_LOW: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            // remaining <= 1 also closes out a corrupted zero count instead of wrapping
            if (remaining_q <= COUNT_W'(1)) begin
              remaining_d = '0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              remaining_d = remaining_q - 1'b1;
              data_d      = 1'b1;
              state_d     = ST_HIGH;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          tick_d      = '0;
          remaining_d = '0;
          data_d      = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (synch_reset) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      remaining_q <= '0;
      data_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_pulse_train_tx.sv
// Directed bench for pulse_train_tx: run-length monitor plus a 10-sample inertial
// filter on the line to confirm every edge survives the far-end debounce.
module tb_pulse_train_tx;
  localparam int HOLD = 12;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic synch_reset;

  pulse_train_tx_if #(.COUNT_W(CW)) bus ();

  pulse_train_tx #(.HOLD_TICKS(HOLD), .COUNT_W(CW)) dut (
    .clk        (clk),
    .synch_reset(synch_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ce_div   = 1;
  int ce_ph    = 0;
  bit ce_off   = 1'b1;
  bit mon_clr  = 1'b0;

  int rises, busy_cyc, done_cyc, hi_total, hi_min, hi_max, cur_run, done_at_fall;
  int f_rises, f_min, f_max, f_run, cyc, d_rise_at, dly_min, dly_max;
  logic prev_d, prev_b, prev_f;

  logic filt_q;
  int   filt_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Far-end inertial filter: output follows the line after 10 consecutive differing CE samples.
  always @(posedge clk) begin
    if (synch_reset) begin
      filt_q   <= 1'b0;
      filt_cnt <= 0;
    end else if (bus.CE) begin
      if (bus.data_out == filt_q) filt_cnt <= 0;
      else if (filt_cnt == 9) begin
        filt_q   <= bus.data_out;
        filt_cnt <= 0;
      end else filt_cnt <= filt_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      rises = 0; busy_cyc = 0; done_cyc = 0; hi_total = 0; hi_min = 9999; hi_max = 0;
      cur_run = 0; done_at_fall = 0; f_rises = 0; f_min = 9999; f_max = 0; f_run = 0;
      cyc = 0; d_rise_at = 0; dly_min = 9999; dly_max = 0;
    end else begin
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) done_cyc++;
      if (prev_b === 1'b1 && !bus.busy && bus.done) done_at_fall++;
      if (bus.data_out) begin
        hi_total++;
        if (prev_d === 1'b1) cur_run++;
        else begin cur_run = 1; rises++; d_rise_at = cyc; end
      end else if (prev_d === 1'b1) begin
        if (cur_run < hi_min) hi_min = cur_run;
        if (cur_run > hi_max) hi_max = cur_run;
      end
      if (filt_q) begin
        if (prev_f === 1'b1) f_run++;
        else begin
          f_run = 1; f_rises++;
          if (cyc - d_rise_at < dly_min) dly_min = cyc - d_rise_at;
          if (cyc - d_rise_at > dly_max) dly_max = cyc - d_rise_at;
        end
      end else if (prev_f === 1'b1) begin
        if (f_run < f_min) f_min = f_run;
        if (f_run > f_max) f_max = f_run;
      end
    end
    prev_d = bus.data_out;
    prev_b = bus.busy;
    prev_f = filt_q;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (ce_off) bus.CE = 1'b0;
    else begin
      ce_ph  = (ce_ph + 1) % ce_div;
      bus.CE = (ce_ph == 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    cycle();
    mon_clr = 1'b0;
  endtask

  task automatic accept(input int n);
    bit was_ce;
    int guard;
    guard          = 0;
    was_ce         = 1'b0;
    bus.num_pulses = n[CW-1:0];
    bus.start      = 1'b1;
    while (!was_ce && guard < 20) begin
      was_ce = bus.CE;
      cycle();
      guard++;
    end
    bus.start = 1'b0;
    check_val("accept_ce_seen", 32'(was_ce), 32'd1);
  endtask

  initial begin
    synch_reset    = 1'b1;
    bus.CE         = 1'b0;
    bus.start      = 1'b0;
    bus.num_pulses = '0;
    run(3);
    check_val("rst_data", 32'(bus.data_out), 0);
    check_val("rst_busy", 32'(bus.busy), 0);
    check_val("rst_done", 32'(bus.done), 0);
    synch_reset = 1'b0;
    ce_off      = 1'b0;
    run(2);

    // three pulses, CE every clk
    clear_mon();
    accept(3);
    check_val("t1_data_rise", 32'(bus.data_out), 1);
    check_val("t1_busy_rise", 32'(bus.busy), 1);
    run(90);
    check_val("t1_rises", rises, 3);
    check_val("t1_hi_min", hi_min, 12);
    check_val("t1_hi_max", hi_max, 12);
    check_val("t1_hi_total", hi_total, 36);
    check_val("t1_busy_cyc", busy_cyc, 72);
    check_val("t1_done_cyc", done_cyc, 1);
    check_val("t1_done_at_fall", done_at_fall, 1);

    // zero-length request
    clear_mon();
    accept(0);
    check_val("t2_done_now", 32'(bus.done), 1);
    run(20);
    check_val("t2_done_cyc", done_cyc, 1);
    check_val("t2_busy_cyc", busy_cyc, 0);
    check_val("t2_rises", rises, 0);

    // CE every 4th clk
    ce_div = 4;
    ce_ph  = 0;
    clear_mon();
    accept(2);
    run(230);
    check_val("t3_rises", rises, 2);
    check_val("t3_hi_min", hi_min, 48);
    check_val("t3_hi_max", hi_max, 48);
    check_val("t3_busy_cyc", busy_cyc, 192);
    check_val("t3_done_cyc", done_cyc, 4);
    check_val("t3_done_at_fall", done_at_fall, 1);
    ce_div = 1;
    ce_ph  = 0;

    // CE hold, then reset mid HIGH of pulse 2 of 5
    clear_mon();
    accept(5);
    run(29);
    check_val("t4_mid_data", 32'(bus.data_out), 1);
    check_val("t4_mid_rises", rises, 2);
    ce_off = 1'b1;
    run(10);
    check_val("t4_hold_data", 32'(bus.data_out), 1);
    check_val("t4_hold_busy", 32'(bus.busy), 1);
    synch_reset = 1'b1;
    cycle();
    check_val("t4_rst_data", 32'(bus.data_out), 0);
    check_val("t4_rst_busy", 32'(bus.busy), 0);
    check_val("t4_rst_done", 32'(bus.done), 0);
    synch_reset = 1'b0;
    run(5);
    check_val("t4_post_busy", 32'(bus.busy), 0);
    ce_off = 1'b0;
    clear_mon();
    accept(1);
    run(40);
    check_val("t4_new_rises", rises, 1);
    check_val("t4_new_hi", hi_max, 12);
    check_val("t4_new_busy", busy_cyc, 24);
    check_val("t4_new_done", done_cyc, 1);

    // start re-pulsed while busy
    clear_mon();
    accept(2);
    run(10);
    bus.num_pulses = 4'd7;
    bus.start      = 1'b1;
    run(3);
    bus.start = 1'b0;
    run(15);
    bus.start = 1'b1;
    run(2);
    bus.start = 1'b0;
    run(40);
    check_val("t5_rises", rises, 2);
    check_val("t5_busy_cyc", busy_cyc, 48);
    check_val("t5_done_cyc", done_cyc, 1);

    // start held high across the return to IDLE
    clear_mon();
    accept(1);
    bus.num_pulses = 4'd1;
    bus.start      = 1'b1;
    run(30);
    bus.start = 1'b0;
    run(40);
    check_val("t6_rises", rises, 2);
    check_val("t6_busy_cyc", busy_cyc, 48);
    check_val("t6_done_cyc", done_cyc, 2);

    // loopback through the inertial filter
    clear_mon();
    accept(15);
    run(400);
    check_val("t7_rises", rises, 15);
    check_val("t7_f_rises", f_rises, 15);
    check_val("t7_f_min", f_min, 12);
    check_val("t7_f_max", f_max, 12);
    check_val("t7_dly_min", dly_min, 10);
    check_val("t7_dly_max", dly_max, 10);
    check_val("t7_f_final", 32'(filt_q), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
